// File: rtl/alu_pkg.sv
// Shared ALU function codes and the multiply sequencer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS_A = 3'd1,
    ABS_B = 3'd2,
    RUN   = 3'd3,
    FIX   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mult_iter_reg.sv
// Shift-add accumulator {acc_hi, acc_lo} with carry capture from the ALU sum.
// Latency: one clock per load or step.
// Backpressure: holds its value whenever neither ld nor step is asserted.
module mult_iter_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_hi,
  input  logic [WIDTH-1:0] ld_lo,
  input  logic             step,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic carry;

  // An unsigned add wrapped around iff the sum is smaller than one addend.
  assign carry = (sum < base);

  // Load has priority; a step shifts the new partial sum (with carry) in from the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (ld) begin
      acc_hi <= ld_hi;
      acc_lo <= ld_lo;
    end else if (step) begin
      {acc_hi, acc_lo} <= {carry, sum, acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_mult_seq.sv
// MIPS mult/multu sequencer borrowing the shared ALU for shift-add iterations (MULT_SIGNED_EN adds signed mode).
// Latency: start to done = WIDTH + 2 granted cycles unsigned; signed adds 2 granted ABS cycles + 1 FIX cycle.
// Backpressure: requests the ALU via alu_req and freezes all state in any cycle alu_gnt is low.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_out
);

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             ld;
  logic [WIDTH-1:0] ld_hi;
  logic [WIDTH-1:0] ld_lo;
  logic             step;
  logic             accept;

`ifdef MULT_SIGNED_EN
  logic             signed_mode;
  logic             neg_flag;
`else
  logic             unused_op_signed;
  assign unused_op_signed = op_signed;
`endif

  // The cycle that shows done is already IDLE, so start is masked there too.
  assign accept = (state == IDLE) && start && !done;

  // ALU operand/function drive, decoded from registered state so it holds across stalls.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_func = ALU_AND;
    case (state)
      RUN: begin
        alu_func = ALU_ADD;
        alu_in1  = acc_hi;
        alu_in2  = acc_lo[0] ? mcand : '0;
      end
`ifdef MULT_SIGNED_EN
      ABS_A: begin
        alu_func = ALU_SUB;
        alu_in2  = mcand;
      end
      ABS_B: begin
        alu_func = ALU_SUB;
        alu_in2  = acc_lo;
      end
`endif
      default: ;
    endcase
  end

  // Accumulator control: operand load, granted iteration, and the signed fix-ups.
  always_comb begin
    ld    = 1'b0;
    ld_hi = '0;
    ld_lo = '0;
    step  = 1'b0;
    if (accept) begin
      ld    = 1'b1;
      ld_lo = op_b;
    end else if (state == RUN && alu_gnt) begin
      step = 1'b1;
    end
`ifdef MULT_SIGNED_EN
    else if (state == ABS_B && alu_gnt && acc_lo[WIDTH-1]) begin
      ld    = 1'b1;
      ld_hi = acc_hi;
      ld_lo = alu_out;
    end else if (state == FIX && neg_flag) begin
      ld             = 1'b1;
      {ld_hi, ld_lo} = -{acc_hi, acc_lo};
    end
`endif
  end

  mult_iter_reg #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .ld_hi  (ld_hi),
    .ld_lo  (ld_lo),
    .step   (step),
    .sum    (alu_out),
    .base   (alu_in1),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Sequencer FSM with registered busy/done/alu_req and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
`ifdef MULT_SIGNED_EN
      signed_mode <= 1'b0;
      neg_flag    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand   <= op_a;
            cnt     <= '0;
            busy    <= 1'b1;
            alu_req <= 1'b1;
`ifdef MULT_SIGNED_EN
            signed_mode <= op_signed;
            neg_flag    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            state       <= op_signed ? ABS_A : RUN;
`else
            state <= RUN;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        ABS_A: begin
          if (alu_gnt) begin
            if (mcand[WIDTH-1]) mcand <= alu_out;
            state <= ABS_B;
          end
        end
        ABS_B: begin
          if (alu_gnt) state <= RUN;
        end
        FIX: begin
          state <= DONE;
        end
`endif
        RUN: begin
          if (alu_gnt) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              alu_req <= 1'b0;
`ifdef MULT_SIGNED_EN
              state <= signed_mode ? FIX : DONE;
`else
              state <= DONE;
`endif
            end
          end
        end
        DONE: begin
          hi    <= acc_hi;
          lo    <= acc_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle MIPS mult/multu sequencer that computes a 64-bit HI/LO product by driving the shared 32-bit ALU through shift-add iterations.
- Sits beside the ALU in the execute stage. Requests the ALU from the main datapath via a grant signal, stalls when not granted, and returns HI/LO with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width; must equal the ALU width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op_signed  in  1  1 = mult, 0 = multu; honoured only with the optional feature.
- op_a  in  WIDTH  multiplicand, sampled with start.
- op_b  in  WIDTH  multiplier, sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when hi/lo are valid.
- hi  out  WIDTH  product [63:32], held until the next accepted start.
- lo  out  WIDTH  product [31:0], held until the next accepted start.
- alu_req  out  1  high while the block needs the ALU.
- alu_gnt  in  1  ALU granted this cycle; the ALU result is consumed in the same cycle.
- alu_in1  out  WIDTH  ALU In1 operand.
- alu_in2  out  WIDTH  ALU In2 operand.
- alu_func  out  4  ALU function code.
- alu_out  in  WIDTH  ALU result (combinational from alu_in1/alu_in2/alu_func).

Behaviour:
- Reset (synchronous): state = IDLE; busy, done, alu_req = 0; hi, lo = 0; alu_in1, alu_in2 = 0; alu_func = ALU_AND.
- IDLE:
  - start = 1 → latch mcand = op_a, acc_hi = 0, acc_lo = op_b, cnt = 0.
  - Next state is ABS_A if signed mode is active, otherwise RUN.
  - busy rises the next cycle.
- RUN (one iteration per granted cycle):
  - Drive alu_func = ALU_ADD (4'b0010), alu_in1 = acc_hi, alu_in2 = acc_lo[0] ? mcand : 0.
  - carry = (alu_out < alu_in1), unsigned compare.
  - Update {acc_hi, acc_lo} <= {carry, alu_out, acc_lo[WIDTH-1:1]}; cnt++.
  - When cnt reaches WIDTH-1 on a granted cycle, next state is FIX (signed) or DONE.
- Grant stall:
  - alu_req = 1 in RUN/ABS_A/ABS_B.
  - When alu_gnt = 0, no register changes; ALU outputs hold their values.
- DONE:
  - hi <= acc_hi, lo <= acc_lo; done = 1 for exactly one cycle; busy = 0 the same cycle; return to IDLE.
- Latency: start → done = 1 + WIDTH granted cycles + 1 (unsigned); +2 granted cycles for ABS and +1 cycle for FIX (signed).
- start while busy is ignored: no queueing, operands not re-latched.
- start in the same cycle as done is ignored; start is accepted only in IDLE.
- Reset mid-operation aborts immediately to the reset values; a partial result never reaches hi/lo.
- alu_req is deasserted in IDLE, DONE and FIX.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - op_signed = 1 enables states ABS_A and ABS_B, one granted cycle each and always taken for signed operations.
  - Each drives alu_func = ALU_SUB (4'b0110), alu_in1 = 0, alu_in2 = operand. The negated operand is latched only if the operand MSB is 1.
  - A sign flag is recorded as op_a[31] ^ op_b[31].
  - FIX state (no ALU use) negates {acc_hi, acc_lo} as a 64-bit two's complement when the flag is set.
- Undefined:
  - op_signed is ignored; all operations are unsigned.
  - No ABS/FIX states and no 64-bit negator logic.

Decomposition:
- Package alu_pkg holds:
  - ALU function-code constants: ALU_AND 4'b0000, ALU_OR 4'b0001, ALU_ADD 4'b0010, ALU_SUB 4'b0110, ALU_SLT 4'b0111, ALU_XOR 4'b1000, ALU_XNOR 4'b1001, ALU_LUI 4'b1110.
  - The state enum: IDLE, ABS_A, ABS_B, RUN, FIX, DONE.
- One natural sub-module, mult_iter_reg: the acc_hi/acc_lo shift register with carry capture. The FSM and ALU drive logic stay in the top.

Test Plan:
- Basic: 3 × 5 unsigned, alu_gnt tied 1 → done after 34 cycles from start; hi = 0, lo = 15.
- Maximum operands: 0xFFFFFFFF × 0xFFFFFFFF unsigned → hi = 0xFFFFFFFE, lo = 0x00000001, which exercises carry capture.
- Grant stall: 7 × 9 with alu_gnt toggling 1/0 each cycle → hi/lo = 0/63; done arrives after 32 granted iterations; registers and ALU outputs stable during gnt = 0 cycles.
- Reset mid-operation: reset asserted at iteration 10 → next cycle busy = 0, hi/lo = 0. A start issued while busy with different operands is ignored.
- Signed (MULT_SIGNED_EN): -2 × 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. -4 × -4 → hi = 0, lo = 16. Without the macro, op_signed = 1 with -2 × 3 gives the unsigned product, hi = 0x00000002, lo = 0xFFFFFFFA.
